// File: rtl/frame_scan_tester.sv
// Frame memory scan tester: reads every block address of a frame in order, compares
// each returned multi-bank word against a counting pattern, and reports errors and passes.
module frame_scan_tester #(
  parameter int H_BLOCKS  = 80,
  parameter int V_BLOCKS  = 60,
  parameter int BANKS     = 4,
  parameter int BANK_W    = 32,
  parameter int ADDR_W    = 15,
  parameter int ADDR_STEP = 4,
  parameter int READ_LAT  = 1
) (
  input  logic                    GCLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    stop,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [BANKS*BANK_W-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             err_count,
  output logic [ADDR_W-1:0]       first_err_addr,
  output logic [15:0]             pass_count,
  output logic                    LD0,
  output logic [1:0]              o_dbg_state
);

  localparam int N     = H_BLOCKS * V_BLOCKS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_drain;
  logic              r_abort;
  logic              r_halt;
  logic              r_pv    [READ_LAT];
  logic [IDX_W-1:0]  r_pidx  [READ_LAT];
  logic [ADDR_W-1:0] r_paddr [READ_LAT];
  logic              r_err;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_first_addr;
  logic              r_first_seen;
  logic [15:0]       r_pass_count;
  logic              r_ld0;

  logic w_start;
  logic w_last_read;
  logic w_last_drain;
  logic w_mismatch;
  logic w_hit;

  assign w_start      = (r_state == S_IDLE) && start && !stop;
  assign w_last_read  = (r_idx == IDX_W'(N - 1));
  assign w_last_drain = (r_state == S_DRAIN) && (r_drain == 2'(READ_LAT - 1));
  assign w_hit        = r_pv[READ_LAT-1] && w_mismatch;

  // The delay line tail lines up with the returning data; compare every bank against the pattern.
  always_comb begin
    w_mismatch = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (rd_data[b*BANK_W +: BANK_W] !=
          (BANK_W'(r_pidx[READ_LAT-1]) * BANK_W'(BANKS) + BANK_W'(b)))
        w_mismatch = 1'b1;
    end
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_addr       <= '0;
      r_drain      <= '0;
      r_abort      <= 1'b0;
      r_halt       <= 1'b0;
      r_pass_count <= '0;
      r_ld0        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_addr  <= '0;
            r_abort <= 1'b0;
            r_halt  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (stop || w_last_read) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
            r_abort <= stop;
            r_idx   <= '0;
            r_addr  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
            r_addr <= r_addr + ADDR_W'(ADDR_STEP);
          end
        end
        S_DRAIN: begin
          if (stop) r_halt <= 1'b1;
          if (w_last_drain) begin
            if (!r_abort) begin
              r_pass_count <= r_pass_count + 16'd1;
              r_ld0        <= ~r_ld0;
            end
            if (!r_abort && !r_halt && !stop && continuous) begin
              r_state <= S_SCAN;
              r_halt  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read tracking pipeline; flushing it on reset discards returns of aborted reads.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      for (int k = 0; k < READ_LAT; k++) begin
        r_pv[k]    <= 1'b0;
        r_pidx[k]  <= '0;
        r_paddr[k] <= '0;
      end
    end else begin
      r_pv[0]    <= (r_state == S_SCAN);
      r_pidx[0]  <= r_idx;
      r_paddr[0] <= r_addr;
      for (int k = 1; k < READ_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_pidx[k]  <= r_pidx[k-1];
        r_paddr[k] <= r_paddr[k-1];
      end
    end
  end

  always_ff @(posedge GCLK) begin
    if (RST || w_start) begin
      r_err        <= 1'b0;
      r_err_count  <= '0;
      r_first_addr <= '0;
      r_first_seen <= 1'b0;
    end else if (w_hit) begin
      r_err <= 1'b1;
      if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      if (!r_first_seen) begin
        r_first_addr <= r_paddr[READ_LAT-1];
        r_first_seen <= 1'b1;
      end
    end
  end

  assign rd_en          = (r_state == S_SCAN);
  assign rd_addr        = r_addr;
  assign busy           = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done           = w_last_drain;
  assign err            = r_err;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_addr;
  assign pass_count     = r_pass_count;
  assign LD0            = r_ld0;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_frame_scan_tester.sv
// Bench for frame_scan_tester on a 4x2 frame: ideal one-cycle memory with fault injection,
// expected reads and end-of-pass status queued by stimulus and checked by a monitor.
module tb_frame_scan_tester;

  localparam int ADDR_W = 15;
  localparam int BANKS  = 4;
  localparam int NREAD  = 8;

  logic                  GCLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  start = 1'b0;
  logic                  continuous = 1'b0;
  logic                  stop = 1'b0;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [BANKS*32-1:0]   rd_data = '0;
  logic                  busy, done, err, LD0;
  logic [15:0]           err_count, pass_count;
  logic [ADDR_W-1:0]     first_err_addr;
  logic [1:0]            dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int fault_mode = 0;  // 0 clean, 1 bank 2 of read 5 zero, 2 every word inverted

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [48:0]       exp_stat_q[$];

  frame_scan_tester #(
    .H_BLOCKS(4), .V_BLOCKS(2), .BANKS(BANKS), .BANK_W(32),
    .ADDR_W(ADDR_W), .ADDR_STEP(4), .READ_LAT(1)
  ) dut (
    .GCLK(GCLK), .RST(RST), .start(start), .continuous(continuous), .stop(stop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
    .first_err_addr(first_err_addr), .pass_count(pass_count), .LD0(LD0),
    .o_dbg_state(dbg_state)
  );

  always #5 GCLK = ~GCLK;

  // Memory model: word for bank b of block i is i*4+b, with optional faults.
  logic [BANKS*32-1:0] mem_word;
  always @(posedge GCLK) begin
    if (rd_en) begin
      for (int b = 0; b < BANKS; b++) begin
        mem_word[b*32 +: 32] = 32'(rd_addr >> 2) * 32'd4 + 32'(b);
        if (fault_mode == 1 && (rd_addr >> 2) == 5 && b == 2) mem_word[b*32 +: 32] = 32'd0;
        if (fault_mode == 2) mem_word[b*32 +: 32] = ~mem_word[b*32 +: 32];
      end
      rd_data <= mem_word;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] stat(input logic e, input logic [15:0] cnt,
                                       input logic [ADDR_W-1:0] fa, input logic [15:0] pc,
                                       input logic ld);
    return {e, cnt, fa, pc, ld};
  endfunction

  // Monitor: compares each issued read, and the status in the cycle after each done pulse.
  logic done_prev = 1'b0;
  always @(negedge GCLK) begin
    if (done_prev) begin
      if (exp_stat_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("pass_status", 64'({err, err_count, first_err_addr, pass_count, LD0}),
                 64'(exp_stat_q.pop_front()));
    end
    if (rd_en) begin
      if (exp_addr_q.size() == 0) check("unexpected_read", 64'(rd_addr) | 64'h1_0000, 64'd0);
      else check("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
    end
    done_prev <= done;
  end

  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(ADDR_W'(i * 4));
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done) begin
        n = k;
        return;
      end
    end
    check({name, "_done_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({rd_en, rd_addr, busy, done, err, err_count, first_err_addr, pass_count, LD0}),
          64'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    check_reset_outputs("reset_state");
    RST = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int n;

  initial begin
    // Clean single pass
    do_reset();
    fault_mode = 0;
    push_reads(NREAD);
    exp_stat_q.push_back(stat(1'b0, 16'd0, '0, 16'd1, 1'b1));
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done("clean", n);
    check("clean_done_latency", 64'(n), 64'd8);
    step();
    step();
    check("clean_idle", 64'(busy), 64'd0);

    // Single fault: bank 2 of read 5
    do_reset();
    fault_mode = 1;
    push_reads(NREAD);
    exp_stat_q.push_back(stat(1'b1, 16'd1, ADDR_W'(20), 16'd1, 1'b1));
    pulse_start();
    wait_done("fault", n);
    step();
    step();
    fault_mode = 0;

    // Continuous, three passes back to back
    do_reset();
    continuous = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      push_reads(NREAD);
      exp_stat_q.push_back(stat(1'b0, 16'd0, '0, 16'(p), p[0]));
    end
    pulse_start();
    wait_done("cont1", n);
    check("cont_interval1", 64'(n), 64'd8);
    wait_done("cont2", n);
    check("cont_interval2", 64'(n), 64'd9);
    step();
    continuous = 1'b0;
    wait_done("cont3", n);
    check("cont_interval3", 64'(n), 64'd8);
    step();
    step();
    check("cont_idle", 64'(busy), 64'd0);

    // Stop during read 3: reads 0..3 issued, aborted pass not counted
    do_reset();
    push_reads(4);
    exp_stat_q.push_back(stat(1'b0, 16'd0, '0, 16'd0, 1'b0));
    pulse_start();
    step();
    step();
    step();
    stop = 1'b1;
    wait_done("stop", n);
    stop = 1'b0;
    check("stop_done_latency", 64'(n), 64'd1);
    step();
    check("stop_idle", 64'(busy), 64'd0);
    step();

    // Reset during read 4 with faulty returns; then a clean pass
    do_reset();
    fault_mode = 2;
    push_reads(5);
    pulse_start();
    step();
    step();
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    fault_mode = 0;
    check_reset_outputs("reset_mid_scan");
    step();
    check("reset_mid_scan_err", 64'({err, err_count}), 64'd0);
    push_reads(NREAD);
    exp_stat_q.push_back(stat(1'b0, 16'd0, '0, 16'd1, 1'b1));
    pulse_start();
    wait_done("after_reset", n);
    step();
    step();

    // Saturation: every read faulty, 8200 continuous passes
    do_reset();
    fault_mode = 2;
    continuous = 1'b1;
    push_reads(NREAD);
    exp_stat_q.push_back(stat(1'b1, 16'd8, '0, 16'd1, 1'b1));
    pulse_start();
    for (int p = 1; p <= 8200; p++) begin
      if (p > 1) begin
        push_reads(NREAD);
        exp_stat_q.push_back(stat(1'b1, (p * 8 > 65535) ? 16'hFFFF : 16'(p * 8), '0,
                                  16'(p), p[0]));
      end
      wait_done("sat", n);
      if (p == 8199) begin
        step();
        continuous = 1'b0;
      end
    end
    step();
    step();
    check("sat_err_count", 64'(err_count), 64'hFFFF);
    check("sat_first_err_addr", 64'(first_err_addr), 64'd0);
    check("sat_idle", 64'(busy), 64'd0);
    fault_mode = 0;

    step();
    check("queues_drained", 64'(exp_addr_q.size() + exp_stat_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/frame_scan_tester.md
FRAME_SCAN_TESTER -- requirements
Module: frame_scan_tester

Interface
REQ-001 The block SHALL have parameter H_BLOCKS, default 80, meaning pixel blocks per frame row.
REQ-002 The block SHALL have parameter V_BLOCKS, default 60, meaning pixel block rows per frame; N = H_BLOCKS*V_BLOCKS reads per pass.
REQ-003 The block SHALL have parameter BANKS, default 4, meaning parallel memory banks read per address.
REQ-004 The block SHALL have parameter BANK_W, default 32, meaning bits per bank word.
REQ-005 The block SHALL have parameter ADDR_W, default 15, meaning read address width; ADDR_W must hold (N-1)*ADDR_STEP.
REQ-006 The block SHALL have parameter ADDR_STEP, default 4, meaning address increment per read.
REQ-007 The block SHALL have parameter READ_LAT, default 1 (range 1-4), meaning cycles from rd_en to valid rd_data.
REQ-008 The block SHALL have ports: GCLK in 1 clock; RST in 1 reset; start in 1 begin scan; continuous in 1 repeat passes; stop in 1 abort request.
REQ-009 The block SHALL have ports: rd_en out 1; rd_addr out ADDR_W; rd_data in BANKS*BANK_W, bank b at bits [b*BANK_W +: BANK_W].
REQ-010 The block SHALL have ports: busy out 1; done out 1; err out 1; err_count out 16; first_err_addr out ADDR_W; pass_count out 16; LD0 out 1 frame-pass indicator.
REQ-011 The block SHALL use one clock, GCLK, with all state updated on its rising edge; RST SHALL be synchronous and active-high.

Function
REQ-012 States SHALL be IDLE, SCAN, DRAIN; busy = 1 in SCAN and DRAIN.
REQ-013 In IDLE, start=1 with stop=0 SHALL clear err, err_count and first_err_addr, then enter SCAN next cycle; start=1 with stop=1 SHALL stay IDLE.
REQ-014 In SCAN, each cycle SHALL assert rd_en with rd_addr = i*ADDR_STEP, for i = 0..N-1 in order, one read per cycle, no gaps.
REQ-015 After read i = N-1 is issued, the FSM SHALL enter DRAIN for exactly READ_LAT cycles, with rd_en = 0.
REQ-016 rd_data SHALL be sampled exactly READ_LAT cycles after each rd_en, via an internal valid/index delay line.
REQ-017 Expected bank b word for read i SHALL be (i*BANKS + b) mod 2^BANK_W; a read mismatches if any bank differs.
REQ-018 Each mismatching read SHALL set err (sticky) and increment err_count by 1, saturating at 16'hFFFF.
REQ-019 first_err_addr SHALL capture rd_addr of the first mismatching read after start and hold until next start or reset.
REQ-020 At the last DRAIN cycle of a complete pass: done pulses 1 cycle, pass_count increments (wraps at 16'hFFFF to 0), LD0 toggles.
REQ-021 After a complete pass, continuous=1 SHALL re-enter SCAN at i=0 on the next cycle without clearing error state; continuous=0 SHALL return to IDLE.
REQ-022 stop=1 in SCAN SHALL cease issuing reads from that cycle, enter DRAIN, compare in-flight data, pulse done, NOT increment pass_count or toggle LD0, then return to IDLE.
REQ-023 stop=1 in DRAIN SHALL suppress continuous restart; the current pass still counts if complete.
REQ-024 start while busy SHALL be ignored.

Reset
REQ-025 RST=1 SHALL force IDLE, rd_en=0, rd_addr=0, busy=0, done=0, err=0, err_count=0, first_err_addr=0, pass_count=0, LD0=0, and flush the delay line.
REQ-026 RST mid-SCAN or mid-DRAIN SHALL abort immediately; returns for reads issued before reset SHALL be ignored.

Verification (H_BLOCKS=4, V_BLOCKS=2, BANKS=4, BANK_W=32, ADDR_STEP=4, READ_LAT=1, ideal memory model)
REQ-027 Clean pass: start pulse, continuous=0 -> rd_addr 0,4,...,28 on 8 consecutive cycles, done 1 cycle after last read, pass_count=1, LD0=1, err=0.
REQ-028 Single fault: bank 2 at read i=5 returns 0 -> err=1, err_count=1, first_err_addr=20, pass_count=1.
REQ-029 Continuous: continuous=1 for 3 passes -> done pulses every 9 cycles, pass_count=3, LD0=1, rd_addr restarts at 0 with no idle cycle.
REQ-030 Stop: stop=1 in SCAN at i=3 -> no rd_en after addr 12, done pulses, pass_count unchanged, LD0 unchanged, busy=0 after.
REQ-031 Reset mid-scan: RST=1 at i=4 -> all outputs at reset values next cycle; new start gives clean pass with err_count=0.
REQ-032 Saturation: all reads faulty, continuous, 8200 passes -> err_count holds 16'hFFFF, first_err_addr=0.
